// File: rtl/ingress_stream_arbiter.sv
// Packet-level round-robin arbiter feeding a single parser ingress from NUM_PORTS
// AXI-Stream sources, with per-packet length limiting and tail drain.
module ingress_stream_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 256,
  parameter int KEEP_W    = 32,
  parameter int MAX_BEATS = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS*DATA_W-1:0]   s_data,
  input  logic [NUM_PORTS*KEEP_W-1:0]   s_keep,
  input  logic [NUM_PORTS-1:0]          s_valid,
  input  logic [NUM_PORTS-1:0]          s_last,
  output logic [NUM_PORTS-1:0]          s_ready,
  output logic [DATA_W-1:0]             m_data,
  output logic [KEEP_W-1:0]             m_keep,
  output logic                          m_valid,
  output logic                          m_last,
  input  logic                          m_ready,
  output logic [$clog2(NUM_PORTS)-1:0]  grant_id,
  output logic                          busy,
  output logic [15:0]                   trunc_count
);

  localparam int ID_W  = $clog2(NUM_PORTS);
  localparam int CNT_W = $clog2(MAX_BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BEATS - 1);
  localparam logic [ID_W-1:0]  PTR_INIT  = ID_W'(NUM_PORTS - 1);

  typedef enum logic [1:0] {IDLE, FORWARD, DRAIN} state_t;

  state_t              state, state_nxt;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     pick;
  logic                found;
  logic [CNT_W-1:0]    beat_cnt;
  logic                at_max;
  logic [DATA_W-1:0]   g_data;
  logic [KEEP_W-1:0]   g_keep;
  logic                g_valid;
  logic                g_last;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign g_data  = s_data[int'(grant_id) * DATA_W +: DATA_W];
  assign g_keep  = s_keep[int'(grant_id) * KEEP_W +: KEEP_W];
  assign g_valid = s_valid[grant_id];
  assign g_last  = s_last[grant_id];
  assign at_max  = (beat_cnt == LAST_BEAT);
  assign busy    = (state != IDLE);

  // Round-robin search starting one past the last port that completed a packet
  always_comb begin
    pick  = rr_ptr;
    found = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (!found && s_valid[(int'(rr_ptr) + k) % NUM_PORTS]) begin
        pick  = ID_W'((int'(rr_ptr) + k) % NUM_PORTS);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    s_ready   = '0;
    m_data    = '0;
    m_keep    = '0;
    m_valid   = 1'b0;
    m_last    = 1'b0;
    case (state)
      IDLE: begin
        if (|s_valid) state_nxt = FORWARD;
      end
      FORWARD: begin
        m_data            = g_data;
        m_keep            = g_keep;
        m_valid           = g_valid;
        m_last            = g_last || at_max;
        s_ready[grant_id] = m_ready;
        if (g_valid && m_ready) begin
          if (g_last)      state_nxt = IDLE;
          else if (at_max) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        s_ready[grant_id] = 1'b1;
        if (g_valid && g_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant_id    <= '0;
      beat_cnt    <= '0;
      rr_ptr      <= PTR_INIT;
      trunc_count <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (|s_valid) begin
            grant_id <= pick;
            beat_cnt <= '0;
          end
        end
        FORWARD: begin
          if (g_valid && m_ready) begin
            if (!at_max) beat_cnt <= beat_cnt + 1'b1;
            // A packet ending exactly on the limit beat is complete, not truncated
            if (g_last)      rr_ptr      <= grant_id;
            else if (at_max) trunc_count <= sat_inc16(trunc_count);
          end
        end
        DRAIN: begin
          if (g_valid && g_last) rr_ptr <= grant_id;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ingress_stream_arbiter.sv
// Bench for ingress_stream_arbiter: queued random packets per port, packet-level
// round-robin expectation model, beat scoreboard and directed timing checks.
module tb_ingress_stream_arbiter;
  localparam int NP   = 4;
  localparam int DW   = 256;
  localparam int KW   = 32;
  localparam int MAXB = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NP*DW-1:0]  s_data;
  logic [NP*KW-1:0]  s_keep;
  logic [NP-1:0]     s_valid, s_last, s_ready;
  logic [DW-1:0]     m_data;
  logic [KW-1:0]     m_keep;
  logic              m_valid, m_last, m_ready;
  logic [1:0]        grant_id;
  logic              busy;
  logic [15:0]       trunc_count;

  always #5 clk = ~clk;

  ingress_stream_arbiter #(
    .NUM_PORTS(NP), .DATA_W(DW), .KEEP_W(KW), .MAX_BEATS(MAXB)
  ) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_keep(s_keep), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_keep(m_keep), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .grant_id(grant_id), .busy(busy), .trunc_count(trunc_count)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    bit            last;
    bit            first;
    int            port;
  } beat_t;

  beat_t       src_q [NP][$];
  beat_t       stg_q [NP][$];
  beat_t       exp_q [$];
  int          n_vec = 0;
  int          n_err = 0;
  int          model_rr = NP - 1;
  int          exp_trunc = 0;
  bit          gap_en = 1'b0;
  bit          rand_rdy = 1'b0;
  logic [NP-1:0] hs;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic add_pkt(input int p, input int len, input bit ones);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.d     = rand_data();
      b.k     = ones ? '1 : KW'($urandom());
      b.last  = (i == len - 1);
      b.first = (i == 0);
      b.port  = p;
      src_q[p].push_back(b);
      stg_q[p].push_back(b);
    end
  endtask

  function automatic bit stg_pending();
    for (int p = 0; p < NP; p++) if (stg_q[p].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit pending();
    for (int p = 0; p < NP; p++) if (src_q[p].size() > 0) return 1'b1;
    return exp_q.size() > 0;
  endfunction

  // Expected output: whole packets in round-robin order, cut to MAXB beats
  task automatic commit();
    beat_t b;
    int    p, n;
    bit    done, found;
    while (stg_pending()) begin
      p = model_rr;
      found = 1'b0;
      for (int k = 1; k <= NP; k++) begin
        if (!found && stg_q[(model_rr + k) % NP].size() > 0) begin
          p = (model_rr + k) % NP;
          found = 1'b1;
        end
      end
      n = 0;
      done = 1'b0;
      while (!done) begin
        b = stg_q[p].pop_front();
        n++;
        done = b.last;
        if (n <= MAXB) begin
          if (n == MAXB) b.last = 1'b1;
          exp_q.push_back(b);
        end
      end
      if (n > MAXB && exp_trunc < 16'hFFFF) exp_trunc++;
      model_rr = p;
    end
  endtask

  task automatic drive_inputs();
    bit gap;
    for (int p = 0; p < NP; p++) begin
      if (src_q[p].size() > 0) begin
        gap = gap_en && !src_q[p][0].first && ($urandom_range(0, 3) == 0);
        s_valid[p]          = !gap;
        s_last[p]           = src_q[p][0].last;
        s_data[p*DW +: DW]  = src_q[p][0].d;
        s_keep[p*KW +: KW]  = src_q[p][0].k;
      end else begin
        s_valid[p]          = 1'b0;
        s_last[p]           = 1'b0;
        s_data[p*DW +: DW]  = '0;
        s_keep[p*KW +: KW]  = '0;
      end
    end
    if (rand_rdy) m_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic advance();
    beat_t e;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat_valid", m_valid, 0);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", m_data, e.d);
        chk("beat_keep", m_keep, e.k);
        chk("beat_last", m_last, e.last);
        chk("beat_grant", grant_id, e.port);
      end
    end
    if (m_valid) chk("ready_mirror", s_ready[grant_id], m_ready);
    chk("ready_onehot", $countones(s_ready) <= 1, 1);
    hs = s_valid & s_ready;
    @(posedge clk);
    for (int p = 0; p < NP; p++) if (hs[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
    @(negedge clk);
  endtask

  task automatic step();
    drive_inputs();
    #1;
    advance();
  endtask

  task automatic run_until_done(input string tag);
    int c = 0;
    while (pending() && c < 3000) begin
      step();
      c++;
    end
    chk({tag, "_timeout"}, c < 3000, 1);
    drive_inputs();
    #1;
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_trunc"}, trunc_count, exp_trunc);
  endtask

  task automatic clear_model();
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      stg_q[p].delete();
    end
    exp_q.delete();
    model_rr  = NP - 1;
    exp_trunc = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_model();
    m_ready = 1'b0;
    drive_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    s_data = '0; s_keep = '0; s_valid = '0; s_last = '0; m_ready = 1'b0;

    do_reset();
    drive_inputs();
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_keep", m_keep, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_trunc", trunc_count, 0);

    // port 2, 3 beats, full keep, ready held high
    gap_en = 1'b0; rand_rdy = 1'b0; m_ready = 1'b1;
    add_pkt(2, 3, 1'b1);
    commit();
    drive_inputs();
    #1;
    chk("t1_arb_busy", busy, 0);
    chk("t1_arb_mvalid", m_valid, 0);
    chk("t1_arb_sready", s_ready, 0);
    advance();
    drive_inputs();
    #1;
    chk("t1_grant", grant_id, 2);
    chk("t1_busy", busy, 1);
    chk("t1_mvalid", m_valid, 1);
    advance();
    run_until_done("t1");

    // all ports request; port 0 has a second packet queued
    do_reset();
    gap_en = 1'b1; rand_rdy = 1'b1;
    add_pkt(0, 2, 1'b0);
    add_pkt(1, 2, 1'b0);
    add_pkt(2, 2, 1'b0);
    add_pkt(3, 2, 1'b0);
    add_pkt(0, 2, 1'b0);
    commit();
    run_until_done("t2");

    // oversize packet: truncated and drained
    do_reset();
    gap_en = 1'b1; rand_rdy = 1'b1;
    add_pkt(1, 70, 1'b0);
    commit();
    run_until_done("t3");
    chk("t3_trunc_one", trunc_count, 1);

    // exactly MAXB beats: not a truncation
    do_reset();
    add_pkt(1, MAXB, 1'b0);
    commit();
    run_until_done("t4");
    chk("t4_trunc_zero", trunc_count, 0);

    // backpressure pattern on port 3
    do_reset();
    gap_en = 1'b0; rand_rdy = 1'b0; m_ready = 1'b1;
    add_pkt(3, 4, 1'b0);
    commit();
    step();
    for (int i = 0; i < 6; i++) begin
      m_ready = pat[i];
      drive_inputs();
      #1;
      chk("t5_sready_mirror", s_ready[3], m_ready);
      advance();
    end
    run_until_done("t5");

    // reset mid-packet, after moving the round-robin pointer off its reset value
    do_reset();
    m_ready = 1'b1;
    add_pkt(0, 1, 1'b0);
    commit();
    run_until_done("t6a");
    add_pkt(2, 5, 1'b0);
    commit();
    step();
    step();
    step();
    drive_inputs();
    rst = 1'b1;
    #1;
    advance();
    rst = 1'b0;
    clear_model();
    drive_inputs();
    #1;
    chk("t6_mvalid", m_valid, 0);
    chk("t6_sready", s_ready, 0);
    chk("t6_busy", busy, 0);
    chk("t6_trunc", trunc_count, 0);
    chk("t6_mlast", m_last, 0);
    add_pkt(1, 1, 1'b0);
    add_pkt(3, 1, 1'b0);
    add_pkt(0, 1, 1'b0);
    commit();
    step();
    drive_inputs();
    #1;
    chk("t6_first_prio", grant_id, 0);
    run_until_done("t6b");

    // random traffic mix
    do_reset();
    gap_en = 1'b1; rand_rdy = 1'b1;
    for (int bt = 0; bt < 4; bt++) begin
      for (int j = 0; j < 6; j++) add_pkt($urandom_range(0, NP - 1), $urandom_range(1, 80), 1'b0);
      commit();
      run_until_done("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ingress_stream_arbiter.md
Name: ingress_stream_arbiter

Overview:
- Packet-level round-robin arbiter that shares the single UDP packet parser ingress among NUM_PORTS AXI-Stream feed sources, such as redundant A/B exchange lines.
- Sits directly in front of the parser input.
- Once a port is granted, the grant is locked until that port's in_last beat, so packets never interleave.
- Enforces a maximum packet length: oversize packets are truncated toward the parser and their remainder is flushed from the source.

Parameters:
NUM_PORTS, 4, number of requesting AXI-Stream sources (2..8)
DATA_W, 256, data width per port in bits
KEEP_W, 32, keep width per port (DATA_W/8)
MAX_BEATS, 64, maximum beats forwarded per packet (>=2)

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
s_data  input  NUM_PORTS*DATA_W  per-port data; port i occupies bits [i*DATA_W +: DATA_W]
s_keep  input  NUM_PORTS*KEEP_W  per-port byte enables
s_valid  input  NUM_PORTS  per-port valid
s_last  input  NUM_PORTS  per-port end of packet
s_ready  output  NUM_PORTS  per-port ready
m_data  output  DATA_W  data to parser
m_keep  output  KEEP_W  keep to parser
m_valid  output  1  valid to parser
m_last  output  1  last to parser
m_ready  input  1  parser ready
grant_id  output  $clog2(NUM_PORTS)  currently/last granted port
busy  output  1  high in FORWARD or DRAIN
trunc_count  output  16  count of truncated packets, saturating at 0xFFFF

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high.
- Reset values: state=IDLE; s_ready=0; m_valid=0; m_last=0; m_data=0; m_keep=0; grant_id=0; busy=0; trunc_count=0; beat_cnt=0; rr_ptr=NUM_PORTS-1 (port 0 has first priority).
- Reset asserted mid-packet aborts immediately; no partial tail is emitted.
- Handshake: a beat transfers when valid && ready on the same edge. Data must not be dropped or duplicated while m_ready is low.

States:
- IDLE
  - m_valid=0, all s_ready=0.
  - If any s_valid is high, pick the first requesting port searching rr_ptr+1, rr_ptr+2, ... modulo NUM_PORTS.
  - Register the pick into grant_id, clear beat_cnt, go to FORWARD.
  - Arbitration costs exactly 1 cycle. No data is accepted in IDLE.
- FORWARD
  - Combinational passthrough with zero added latency:
    - m_data/m_keep/m_valid = port grant_id's signals.
    - s_ready[grant_id] = m_ready; all other s_ready = 0.
  - m_last = s_last[grant_id] OR (beat_cnt == MAX_BEATS-1).
  - On each accepted beat, beat_cnt increments.
  - Accepted beat with s_last high: set rr_ptr = grant_id, go to IDLE.
  - Accepted beat with beat_cnt == MAX_BEATS-1 and s_last low: forced m_last. Increment trunc_count (saturating). Go to DRAIN.
  - If both conditions hold on the same beat, this is not a truncation: go to IDLE and leave trunc_count unchanged.
- DRAIN
  - m_valid=0; s_ready[grant_id]=1; others 0.
  - Discard beats until a beat with s_valid && s_last is accepted.
  - Then set rr_ptr = grant_id, go to IDLE.
- Valid dropped mid-packet (s_valid low while in FORWARD): stay in FORWARD, m_valid=0. No timeout.
- Fairness: a port that has just finished cannot win again while any other port requests.
  - With NUM_PORTS requesters continuously active, each port gets exactly one packet per round.
- busy = (state != IDLE). grant_id holds its value in IDLE.
- Widths: beat_cnt is $clog2(MAX_BEATS) bits and never wraps; it is cleared on every grant.
- Non-granted ports are unaffected by the granted port's activity and see s_ready=0 until they are granted.

Test Plan:
- Reset, then port 2 sends a 3-beat packet (keep=0xFFFFFFFF, last on beat 3) with m_ready=1 -> grant_id=2 one cycle after s_valid; 3 beats appear on m_* unchanged with m_last on the 3rd; busy drops the next cycle.
- All 4 ports hold a 2-beat packet valid simultaneously -> grant order 0,1,2,3,0; no interleaving; each packet's m_last aligns with its source s_last.
- Port 1 sends a 70-beat packet with MAX_BEATS=64 -> 64 beats forwarded, m_last on beat 64; beats 65-70 accepted with m_valid=0; trunc_count=1; then IDLE.
- Exactly 64-beat packet with s_last on beat 64 -> m_last on beat 64; trunc_count stays 0; no DRAIN.
- m_ready toggles 1,0,0,1 during a 4-beat packet on port 3 -> s_ready[3] mirrors m_ready; beats stall and deliver in order with no loss or duplication.
- rst pulsed for 1 cycle on beat 2 of a 5-beat packet -> next cycle m_valid=0, s_ready=0, busy=0, trunc_count=0, and port 0 has first priority afterward.
